// File: rtl/aes_sec_pkg.sv
// Shared types and helpers for the AES security-engine behavioural model.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package aes_sec_pkg;

    typedef enum logic [1:0] {
        AES_M128,
        AES_M192,
        AES_M256
    } aesMode_t;

    typedef enum logic [1:0] {
        KS_NOKEY,
        KS_EXPAND,
        KS_READY
    } keyState_t;

    // Key-expansion stall lengths, one per key size
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // Helpers work on a fixed wide vector so one definition serves every
    // DATA_W; callers zero-extend in and slice the low DATA_W bits out.
    // DATA_W must therefore stay below MAX_W.
    localparam int MAX_W  = 512;
    localparam int MAX_AW = 9;

    function automatic logic [3:0] nrOf(input aesMode_t m);
        case (m)
            AES_M192: return NR_192;
            AES_M256: return NR_256;
            default:  return NR_128;
        endcase
    endfunction

    // 192-bit keys only fold in the low half of the upper key word
    function automatic logic [MAX_W-1:0] maskOf(input logic [MAX_W-1:0] lo,
                                                input logic [MAX_W-1:0] hi,
                                                input aesMode_t m,
                                                input int w);
        logic [MAX_W-1:0] halfHi;
        halfHi = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w / 2) halfHi[MAX_AW'(i)] = hi[MAX_AW'(i)];
        end
        case (m)
            AES_M192: return lo ^ halfHi;
            AES_M256: return lo ^ hi;
            default:  return lo;
        endcase
    endfunction

    // Rotate the low w bits of x left by r; bits above w stay zero
    function automatic logic [MAX_W-1:0] rotlW(input logic [MAX_W-1:0] x, input int w, input int r);
        logic [MAX_W-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) res[MAX_AW'((i + r) % w)] = x[MAX_AW'(i)];
        end
        return res;
    endfunction

    // Rotate the low w bits of x right by r; bits above w stay zero
    function automatic logic [MAX_W-1:0] rotrW(input logic [MAX_W-1:0] x, input int w, input int r);
        logic [MAX_W-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) res[MAX_AW'(i)] = x[MAX_AW'((i + r) % w)];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_sec_out_fifo.sv
// First-word-fall-through output buffer with occupancy count.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: pops only when outVld && !outStall; the writer must never push when full without a pop.
module aes_sec_out_fifo #(
    parameter int W     = 129,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pushVld,
    input  logic [W-1:0]              pushDat,
    input  logic                      outStall,
    output logic                      outVld,
    output logic [W-1:0]              outDat,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wrPtr;
    logic [AW:0]  rdPtr;
    logic [W-1:0] mem [DEPTH];
    logic         popEn;

    // Extra pointer MSB separates full from empty when the indices match
    assign empty  = (wrPtr == rdPtr);
    assign count  = wrPtr - rdPtr;
    assign outVld = !empty;
    assign popEn  = outVld && !outStall;
    // Gate the head so stale storage never appears at the output
    assign outDat = empty ? '0 : mem[rdPtr[AW-1:0]];

    // Pointer update; push and pop in one cycle leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushVld) wrPtr <= wrPtr + 1'b1;
            if (popEn)   rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until the pointer covers them
    always_ff @(posedge clk) begin
        if (pushVld) mem[wrPtr[AW-1:0]] <= pushDat;
    end

endmodule

// File: rtl/aes_sec_model_pipe.sv
// Cycle-accurate AES engine stand-in: key-expansion stall, fixed-latency XOR/rotate cipher, FWFT output buffer.
// Latency: block accepted in cycle t is visible at the output in cycle t+LATENCY (empty buffer); key load stalls Nr cycles.
// Backpressure: credit-based; CiphInStall rises once buffered plus in-flight blocks reach FIFO_DEPTH, the pipeline never stalls.
module aes_sec_model_pipe
    import aes_sec_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int KEY_W      = 256,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ROT        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Aes128,
    input  logic              Aes192,
    input  logic              Aes256,
    input  logic [KEY_W-1:0]  KeyIn,
    input  logic              KeyInitVldR,
    output logic              KeyInitStall,
    input  logic [DATA_W-1:0] CiphIn,
    input  logic              CiphInVldR,
    input  logic              CiphInLastR,
    input  logic              EncryptEn,
    output logic              CiphInStall,
    output logic [DATA_W-1:0] AesCiphOutR,
    output logic              AesCiphOutVldR,
    output logic              AesCiphOutLastR,
    input  logic              AesCiphOutStall
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;

    keyState_t         keyState;
    keyState_t         keyStateNxt;
    logic [3:0]        keyCnt;
    logic [3:0]        keyCntNxt;
    aesMode_t          keyMode;
    aesMode_t          modeSel;
    logic [KEY_W-1:0]  keyLatch;
    logic              keyAccept;
    logic              ciphAccept;
    logic              idle;

    logic [MAX_W-1:0]  maskWide;
    logic [MAX_W-1:0]  encWide;
    logic [MAX_W-1:0]  decWide;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] xformDat;
    logic              unusedBits;

    logic [CW-1:0]     inflight;
    logic              pushVld;
    logic [DATA_W:0]   pushDat;
    logic [DATA_W:0]   fifoOutDat;
    logic [AW:0]       fifoCount;
    logic              fifoEmpty;

    // Widest requested key size wins; no select at all means 128
    assign modeSel = Aes256 ? AES_M256 : (Aes192 ? AES_M192 : AES_M128);

    // Key FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyState <= KS_NOKEY;
            keyCnt   <= '0;
        end else begin
            keyState <= keyStateNxt;
            keyCnt   <= keyCntNxt;
        end
    end

    // Key FSM next state; reload is only admitted once the datapath has drained
    always_comb begin
        keyStateNxt  = keyState;
        keyCntNxt    = keyCnt;
        KeyInitStall = 1'b0;
        case (keyState)
            KS_NOKEY:  KeyInitStall = 1'b0;
            KS_EXPAND: begin
                KeyInitStall = 1'b1;
                keyCntNxt    = keyCnt - 4'd1;
                if (keyCnt == 4'd1) keyStateNxt = KS_READY;
            end
            KS_READY:  KeyInitStall = !idle;
            default:   keyStateNxt = KS_NOKEY;
        endcase
        keyAccept = KeyInitVldR && !KeyInitStall;
        if (keyAccept) begin
            keyStateNxt = KS_EXPAND;
            keyCntNxt   = nrOf(modeSel);
        end
    end

    // Key material and mode are captured at accept and held until the next reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyLatch <= '0;
            keyMode  <= AES_M128;
        end else if (keyAccept) begin
            keyLatch <= KeyIn;
            keyMode  <= modeSel;
        end
    end

    assign maskWide = maskOf(MAX_W'(keyLatch[DATA_W-1:0]), MAX_W'(keyLatch[KEY_W-1:DATA_W]),
                             keyMode, DATA_W);
    assign mask     = maskWide[DATA_W-1:0];

    // Decrypt undoes encrypt step for step: rotate back first, then remove the mask
    assign encWide  = rotlW(MAX_W'(CiphIn ^ mask), DATA_W, ROT);
    assign decWide  = rotrW(MAX_W'(CiphIn), DATA_W, ROT);
    assign xformDat = EncryptEn ? encWide[DATA_W-1:0] : (decWide[DATA_W-1:0] ^ mask);

    // Upper bits of the wide helper results are always zero
    assign unusedBits = ^{maskWide[MAX_W-1:DATA_W], encWide[MAX_W-1:DATA_W], decWide[MAX_W-1:DATA_W]};

    // Credit: every block in flight already owns a buffer slot
    assign CiphInStall = (keyState != KS_READY) ||
                         ((CW'(fifoCount) + inflight) >= CW'(FIFO_DEPTH));
    assign ciphAccept  = CiphInVldR && !CiphInStall;
    assign idle        = (inflight == '0) && fifoEmpty;

    generate
        if (LATENCY == 1) begin : gNoPipe
            // Single-cycle latency writes the transform straight into the buffer
            assign pushVld  = ciphAccept;
            assign pushDat  = {CiphInLastR, xformDat};
            assign inflight = '0;
        end else begin : gPipe
            localparam int PS = LATENCY - 1;

            logic [PS-1:0]   pipeVld;
            logic [DATA_W:0] pipeDat [PS];

            // Free-running shift of {last, data}; stage 0 holds the registered transform
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipeVld <= '0;
                    for (int i = 0; i < PS; i++) pipeDat[i] <= '0;
                end else begin
                    pipeVld[0] <= ciphAccept;
                    pipeDat[0] <= {CiphInLastR, xformDat};
                    for (int i = 1; i < PS; i++) begin
                        pipeVld[i] <= pipeVld[i-1];
                        pipeDat[i] <= pipeDat[i-1];
                    end
                end
            end

            // Count occupied stages for the credit check
            always_comb begin
                inflight = '0;
                for (int i = 0; i < PS; i++) inflight = inflight + CW'(pipeVld[i]);
            end

            assign pushVld = pipeVld[PS-1];
            assign pushDat = pipeDat[PS-1];
        end
    endgenerate

    aes_sec_out_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) uOutFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .pushVld  (pushVld),
        .pushDat  (pushDat),
        .outStall (AesCiphOutStall),
        .outVld   (AesCiphOutVldR),
        .outDat   (fifoOutDat),
        .count    (fifoCount),
        .empty    (fifoEmpty)
    );

    assign AesCiphOutR     = fifoOutDat[DATA_W-1:0];
    assign AesCiphOutLastR = fifoOutDat[DATA_W];

endmodule

// File: doc/aes_sec_model_pipe.md
Name: aes_sec_model_pipe

Overview:
- Parametrised, cycle-accurate behavioural model of the AES security engine interface.
- Replaces the constant-output stub in compression/encryption datapath integrations.
- Models key-expansion stall time, a fixed-latency cipher pipeline, an output buffer with back-pressure, and last-beat tagging.
- The cipher is a reversible XOR/rotate transform, not real AES, so encrypt-then-decrypt round trips are checkable by upstream benches.

Parameters:
- DATA_W, 128: cipher block width in bits. Must be a multiple of 8 and ≥ 16.
- KEY_W, 256: key input width. Must be 2*DATA_W.
- LATENCY, 4: cycles from input accept to output-buffer write. Range 1..16.
- FIFO_DEPTH, 8: output buffer entries. Power of 2, ≥ 2.
- ROT, 8: encrypt rotate-left amount in bits. Must be < DATA_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- Aes128  in  1  key-size select, sampled at key accept.
- Aes192  in  1  key-size select, sampled at key accept.
- Aes256  in  1  key-size select, sampled at key accept.
- KeyIn  in  KEY_W  key material.
- KeyInitVldR  in  1  key load request.
- KeyInitStall  out  1  key not accepted this cycle.
- CiphIn  in  DATA_W  input block.
- CiphInVldR  in  1  input valid.
- CiphInLastR  in  1  last block of stream.
- EncryptEn  in  1  1 = encrypt, 0 = decrypt; sampled per block.
- CiphInStall  out  1  input not accepted this cycle.
- AesCiphOutR  out  DATA_W  output block.
- AesCiphOutVldR  out  1  output valid.
- AesCiphOutLastR  out  1  last tag of output block.
- AesCiphOutStall  in  1  downstream back-pressure.

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous, active-low (rst_n). All state clears immediately on reset assertion.
- Reset values:
  - KeyInitStall = 0, CiphInStall = 1.
  - AesCiphOutVldR = 0, AesCiphOutR = 0, AesCiphOutLastR = 0.
  - Key state = NOKEY, pipeline and FIFO empty.
- Key FSM states: NOKEY, EXPAND, READY.
  - Key accept = KeyInitVldR && !KeyInitStall. Allowed in NOKEY, and in READY only when idle.
  - On accept, latch KeyIn and the mode. Mode priority: Aes256 > Aes192 > Aes128; none set defaults to 128.
  - Go to EXPAND and load a counter with Nr = 10, 12 or 14 for 128, 192 or 256.
  - EXPAND: KeyInitStall = 1; decrement each cycle; at counter = 1, go to READY next cycle. KeyInitStall is high for exactly Nr cycles after accept.
  - Idle means pipeline empty and FIFO empty. KeyInitStall = 1 in READY while not idle. KeyInitStall = 0 in NOKEY.
  - Key reload is only possible once idle; the new key takes effect only after the next EXPAND completes.
- Mask, computed from the latched key (lo = KeyIn[DATA_W-1:0], hi = upper half):
  - 128: mask = lo.
  - 192: mask = lo ^ zero-extended hi[DATA_W/2-1:0].
  - 256: mask = lo ^ hi.
- Transform:
  - Encrypt: out = rotl(CiphIn ^ mask, ROT).
  - Decrypt: out = rotr(CiphIn, ROT) ^ mask.
- Input accept = CiphInVldR && !CiphInStall.
  - CiphInStall = (state != READY) || (fifo_count + inflight >= FIFO_DEPTH).
  - inflight counts valid pipeline stages. Credit is reserved at accept, so the FIFO never overflows and no block is dropped.
  - CiphInVldR while stalled is ignored. The source holds its data.
- Pipeline: LATENCY-stage shift of {valid, data, last}; the transform result is registered in stage 1.
  - A block accepted in cycle t is written to the FIFO at the end of cycle t+LATENCY-1.
  - It is visible at the output in cycle t+LATENCY if the FIFO was empty.
  - The pipeline never stalls; back-pressure is absorbed by the credit.
- Output FIFO is first-word-fall-through.
  - AesCiphOutVldR = !empty, independent of AesCiphOutStall.
  - Pop = AesCiphOutVldR && !AesCiphOutStall.
  - Data and last are held stable while stalled.
- Simultaneous push and pop keeps the count unchanged; it is legal when full because credit guarantees space after the pop.
- Pointer wrap-around uses log2(FIFO_DEPTH)+1-bit pointers; full/empty come from the MSB compare.
- Throughput is one block per cycle when there is no back-pressure.

Decomposition:
- Shared package (aes_sec_pkg):
  - Mode enum {AES_M128, AES_M192, AES_M256}.
  - Nr constants 10, 12, 14.
  - Key FSM state enum.
  - Mask-function and rotate-function definitions.
- One sub-module: aes_sec_out_fifo, a parametrised FWFT FIFO with count output.

Test Plan:
- Key load timing:
  - Stimulus: Aes128, KeyIn low = 128'h000102030405060708090a0b0c0d0e0f, one-cycle KeyInitVldR.
  - Response: KeyInitStall high exactly 10 cycles, CiphInStall deasserts the cycle after.
  - Repeat with Aes256: 14 cycles.
- Encrypt vector:
  - Stimulus: after the 128 key, CiphIn = 0, EncryptEn = 1, accepted at cycle t.
  - Response: AesCiphOutR = 128'h0102030405060708090a0b0c0d0e0f00 with VldR high at t+4, Last propagated.
- Round trip:
  - Stimulus: 16 random blocks encrypted, then fed back with EncryptEn = 0.
  - Response: outputs equal the originals for modes 128, 192 and 256.
- Back-pressure:
  - Stimulus: hold AesCiphOutStall = 1, stream CiphInVldR continuously.
  - Response: exactly 8 blocks accepted, then CiphInStall = 1; release gives in-order output with no loss and no duplicates.
- Key reload while busy:
  - Stimulus: KeyInitVldR while 3 blocks are in flight.
  - Response: KeyInitStall = 1 until drained; in-flight blocks use the old mask, later blocks the new one.
- Reset mid-stream:
  - Stimulus: assert rst_n = 0 with FIFO holding 5 blocks.
  - Response: VldR = 0 immediately, CiphInStall = 1, state NOKEY; no stale output after reset release.
